// File: rtl/fdtd_step_sequencer_if.sv
// Handshake bundle between the FDTD step sequencer and the Hy/Ez/source calc engines.
// The sequencer raises one start enable per phase; each engine answers with a level done flag.
interface fdtd_step_sequencer_if;
    logic calc_Hy_start_en_o;
    logic calc_Ez_start_en_o;
    logic calc_src_start_en_o;
    logic calc_Hy_end_flg_i;
    logic calc_Ez_end_flg_i;
    logic calc_src_end_flg_i;

    modport master (
        output calc_Hy_start_en_o, calc_Ez_start_en_o, calc_src_start_en_o,
        input  calc_Hy_end_flg_i,  calc_Ez_end_flg_i,  calc_src_end_flg_i
    );

    modport slave (
        input  calc_Hy_start_en_o, calc_Ez_start_en_o, calc_src_start_en_o,
        output calc_Hy_end_flg_i,  calc_Ez_end_flg_i,  calc_src_end_flg_i
    );
endinterface

// File: rtl/fdtd_step_sequencer.sv
// Runs the FDTD datapath through N timesteps (Hy -> Ez -> source -> sample -> step end),
// with per-phase timeout, abort and a sticky completion/timeout interrupt.
module fdtd_step_sequencer #(
    parameter int unsigned STEP_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  clr_int_i,
    input  logic                  int_en_i,
    input  logic [STEP_W-1:0]     num_steps_i,
    fdtd_step_sequencer_if.master eng,
    output logic                  sample_strobe_o,
    output logic                  field_update_end_o,
    output logic [STEP_W-1:0]     step_cnt_o,
    output logic                  busy_o,
    output logic                  int_pending_o,
    output logic                  timeout_o,
    output logic                  int_o
);

    localparam int unsigned PH_W = $clog2(TIMEOUT_CYC);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HY, S_EZ, S_SRC, S_SAMPLE, S_STEP_END
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_cyc_q, phase_cyc_d;
    logic [STEP_W-1:0] num_steps_q, num_steps_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic              hy_en_q, hy_en_d;
    logic              ez_en_q, ez_en_d;
    logic              src_en_q, src_en_d;
    logic              strobe_q, strobe_d;
    logic              fue_q, fue_d;
    logic              busy_q, busy_d;
    logic              int_pend_q, int_pend_d;
    logic              timeout_q, timeout_d;
    logic              phase_flg;
    logic              set_int;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= S_IDLE;
            phase_cyc_q <= '0;
            num_steps_q <= '0;
            step_cnt_q  <= '0;
            hy_en_q     <= 1'b0;
            ez_en_q     <= 1'b0;
            src_en_q    <= 1'b0;
            strobe_q    <= 1'b0;
            fue_q       <= 1'b0;
            busy_q      <= 1'b0;
            int_pend_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_cyc_q <= phase_cyc_d;
            num_steps_q <= num_steps_d;
            step_cnt_q  <= step_cnt_d;
            hy_en_q     <= hy_en_d;
            ez_en_q     <= ez_en_d;
            src_en_q    <= src_en_d;
            strobe_q    <= strobe_d;
            fue_q       <= fue_d;
            busy_q      <= busy_d;
            int_pend_q  <= int_pend_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        num_steps_d = num_steps_q;
        step_cnt_d  = step_cnt_q;
        timeout_d   = timeout_q;
        set_int     = 1'b0;
        phase_flg   = 1'b0;

        case (state_q)
            S_HY:    phase_flg = eng.calc_Hy_end_flg_i;
            S_EZ:    phase_flg = eng.calc_Ez_end_flg_i;
            S_SRC:   phase_flg = eng.calc_src_end_flg_i;
            default: phase_flg = 1'b0;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start_i && (num_steps_i != '0)) begin
                    num_steps_d = num_steps_i;
                    step_cnt_d  = '0;
                    timeout_d   = 1'b0;
                    state_d     = S_HY;
                end
            end
            S_HY, S_EZ, S_SRC: begin
                // first cycle of a phase ignores the flag: it may be stale from the previous step
                if (phase_flg && (phase_cyc_q != '0)) begin
                    state_d = (state_q == S_HY) ? S_EZ : ((state_q == S_EZ) ? S_SRC : S_SAMPLE);
                end else if (phase_cyc_q == PH_LAST) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                    set_int   = 1'b1;
                end
            end
            S_SAMPLE: state_d = S_STEP_END;
            S_STEP_END: begin
                step_cnt_d = step_cnt_q + STEP_W'(1);
                if (step_cnt_d == num_steps_q) begin
                    state_d = S_IDLE;
                    set_int = 1'b1;
                end else begin
                    state_d = S_HY;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // abort overrides any phase progress, timeout or completion in this cycle
        if (abort_i && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            step_cnt_d = step_cnt_q;
            timeout_d  = timeout_q;
            set_int    = 1'b0;
        end

        if ((state_d != state_q) || (state_d == S_IDLE)) begin
            phase_cyc_d = '0;
        end else if (phase_cyc_q == PH_LAST) begin
            phase_cyc_d = phase_cyc_q;
        end else begin
            phase_cyc_d = phase_cyc_q + PH_W'(1);
        end

        int_pend_d = set_int ? 1'b1 : (clr_int_i ? 1'b0 : int_pend_q);
        hy_en_d    = (state_d == S_HY);
        ez_en_d    = (state_d == S_EZ);
        src_en_d   = (state_d == S_SRC);
        strobe_d   = (state_d == S_SAMPLE);
        fue_d      = (state_d == S_STEP_END);
        busy_d     = (state_d != S_IDLE);
    end

    assign eng.calc_Hy_start_en_o  = hy_en_q;
    assign eng.calc_Ez_start_en_o  = ez_en_q;
    assign eng.calc_src_start_en_o = src_en_q;
    assign sample_strobe_o         = strobe_q;
    assign field_update_end_o      = fue_q;
    assign step_cnt_o              = step_cnt_q;
    assign busy_o                  = busy_q;
    assign int_pending_o           = int_pend_q;
    assign timeout_o               = timeout_q;
    assign int_o                   = int_pend_q & int_en_i;

endmodule

// File: tb/tb_fdtd_step_sequencer.sv
// Bench for fdtd_step_sequencer: directed scenarios plus random runs against a
// phase-list reference model, compared every cycle.
module tb_fdtd_step_sequencer;
    localparam int unsigned STEP_W = 16;
    localparam int unsigned TO     = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0, abort_i = 1'b0, clr_int_i = 1'b0, int_en_i = 1'b0;
    logic [STEP_W-1:0] num_steps_i = '0;
    logic              sample_strobe_o, field_update_end_o, busy_o, int_pending_o, timeout_o, int_o;
    logic [STEP_W-1:0] step_cnt_o;

    fdtd_step_sequencer_if eng_if ();

    fdtd_step_sequencer #(.STEP_W(STEP_W), .TIMEOUT_CYC(TO)) dut (
        .ACLK(clk), .ARESETn(rst_n), .start_i(start_i), .abort_i(abort_i),
        .clr_int_i(clr_int_i), .int_en_i(int_en_i), .num_steps_i(num_steps_i),
        .eng(eng_if.master), .sample_strobe_o(sample_strobe_o),
        .field_update_end_o(field_update_end_o), .step_cnt_o(step_cnt_o),
        .busy_o(busy_o), .int_pending_o(int_pending_o), .timeout_o(timeout_o), .int_o(int_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Engine emulation: done flag rises dly cycles into the enable (dly 0 = never), or stuck high
    int dly [3];
    bit stuck [3];
    int ecnt [3];
    always @(negedge clk) begin
        logic [2:0] en;
        logic [2:0] fl;
        en = {eng_if.calc_src_start_en_o, eng_if.calc_Ez_start_en_o, eng_if.calc_Hy_start_en_o};
        for (int i = 0; i < 3; i++) begin
            if (en[i] === 1'b1) ecnt[i]++;
            else ecnt[i] = 0;
            fl[i] = stuck[i] || ((en[i] === 1'b1) && (dly[i] > 0) && (ecnt[i] >= dly[i]));
        end
        eng_if.calc_Hy_end_flg_i  = fl[0];
        eng_if.calc_Ez_end_flg_i  = fl[1];
        eng_if.calc_src_end_flg_i = fl[2];
    end

    // Reference model: phase index 0=idle,1=Hy,2=Ez,3=src,4=sample,5=step end
    int m_phase, m_cyc, m_steps, m_n, m_nx;
    bit m_ip, m_to, m_set, m_fl;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_cyc = 0; m_steps = 0; m_n = 0; m_ip = 0; m_to = 0;
        end else begin
            m_nx = m_phase;
            m_set = 0;
            m_fl = (m_phase == 1) ? eng_if.calc_Hy_end_flg_i :
                   (m_phase == 2) ? eng_if.calc_Ez_end_flg_i :
                   (m_phase == 3) ? eng_if.calc_src_end_flg_i : 1'b0;
            if (m_phase == 0) begin
                if (start_i && num_steps_i != 0) begin
                    m_n = int'(num_steps_i); m_steps = 0; m_to = 0; m_nx = 1;
                end
            end else if (abort_i) begin
                m_nx = 0;
            end else if (m_phase <= 3) begin
                if (m_fl && m_cyc >= 1) m_nx = m_phase + 1;
                else if (m_cyc == TO - 1) begin m_nx = 0; m_to = 1; m_set = 1; end
            end else if (m_phase == 4) begin
                m_nx = 5;
            end else begin
                m_steps++;
                if (m_steps == m_n) begin m_nx = 0; m_set = 1; end
                else m_nx = 1;
            end
            m_cyc = (m_nx != m_phase || m_nx == 0) ? 0 : ((m_cyc < TO - 1) ? m_cyc + 1 : m_cyc);
            if (m_set) m_ip = 1;
            else if (clr_int_i) m_ip = 0;
            m_phase = m_nx;
        end
    end

    // Per-cycle comparison plus activity tallies for the directed scenarios
    int n_strobe = 0, n_fue = 0, n_hy = 0, n_ez = 0, n_src = 0;
    int seq[$];
    logic [2:0] prev_en = '0;
    always @(posedge clk) begin
        logic [8:0] act, exp;
        #2;
        act = {eng_if.calc_Hy_start_en_o, eng_if.calc_Ez_start_en_o, eng_if.calc_src_start_en_o,
               sample_strobe_o, field_update_end_o, busy_o, int_pending_o, timeout_o, int_o};
        exp = {m_phase == 1, m_phase == 2, m_phase == 3, m_phase == 4, m_phase == 5,
               m_phase != 0, m_ip, m_to, m_ip & int_en_i};
        chk("outputs{hy,ez,src,strb,fue,busy,ip,to,int}", 32'(act), 32'(exp));
        chk("step_cnt", 32'(step_cnt_o), 32'(m_steps));
        if (sample_strobe_o) n_strobe++;
        if (field_update_end_o) n_fue++;
        if (eng_if.calc_Hy_start_en_o) n_hy++;
        if (eng_if.calc_Ez_start_en_o) n_ez++;
        if (eng_if.calc_src_start_en_o) n_src++;
        if (eng_if.calc_Hy_start_en_o && !prev_en[0]) seq.push_back(1);
        if (eng_if.calc_Ez_start_en_o && !prev_en[1]) seq.push_back(2);
        if (eng_if.calc_src_start_en_o && !prev_en[2]) seq.push_back(3);
        prev_en = {eng_if.calc_src_start_en_o, eng_if.calc_Ez_start_en_o, eng_if.calc_Hy_start_en_o};
    end

    task automatic do_start(input int n);
        start_i = 1'b1;
        num_steps_i = STEP_W'(n);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int max);
        int k = 0;
        while (busy_o && k < max) begin @(negedge clk); k++; end
        if (busy_o) begin
            checks++; failures++;
            $display("FAIL %s: still busy after %0d cycles", nm, max);
        end
    endtask

    task automatic wait_for(input string nm, input bit want_ez, input int want_step, input int max);
        int k = 0;
        while (!((want_ez ? eng_if.calc_Ez_start_en_o : field_update_end_o) &&
                 int'(step_cnt_o) == want_step) && k < max) begin
            @(negedge clk); k++;
        end
        if (k >= max) begin
            checks++; failures++;
            $display("FAIL %s: condition not reached in %0d cycles", nm, max);
        end
    endtask

    task automatic pulse_clr();
        clr_int_i = 1'b1;
        @(negedge clk);
        clr_int_i = 1'b0;
    endtask

    initial begin
        int base, b_strobe, b_fue, b_ez, b_src;
        for (int i = 0; i < 3; i++) begin dly[i] = 4; stuck[i] = 0; end
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({busy_o, int_pending_o, timeout_o, int_o, sample_strobe_o,
                                  field_update_end_o, eng_if.calc_Hy_start_en_o}), 32'd0);
        chk("reset_step_cnt", 32'(step_cnt_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: N=3 with engines answering after 4 cycles
        int_en_i = 1'b1;
        base = seq.size(); b_strobe = n_strobe; b_fue = n_fue;
        do_start(3);
        wait_idle("t1_idle", 200);
        chk("t1_step_cnt", 32'(step_cnt_o), 32'd3);
        chk("t1_int_o", 32'(int_o), 32'd1);
        chk("t1_strobes", 32'(n_strobe - b_strobe), 32'd3);
        chk("t1_fue", 32'(n_fue - b_fue), 32'd3);
        chk("t1_order_len", 32'(seq.size() - base), 32'd9);
        for (int i = 0; i < 9 && base + i < seq.size(); i++)
            chk("t1_order", 32'(seq[base + i]), 32'((i % 3) + 1));
        pulse_clr();

        // 2: Ez flag stuck high before the run
        stuck[1] = 1; b_ez = n_ez; b_strobe = n_strobe;
        do_start(1);
        wait_idle("t2_idle", 100);
        chk("t2_ez_cycles", 32'(n_ez - b_ez), 32'd2);
        chk("t2_strobes", 32'(n_strobe - b_strobe), 32'd1);
        stuck[1] = 0;
        pulse_clr();

        // 3: source engine never answers
        dly[2] = 0; b_src = n_src;
        do_start(2);
        wait_idle("t3_idle", 100);
        chk("t3_src_cycles", 32'(n_src - b_src), 32'd16);
        chk("t3_timeout", 32'(timeout_o), 32'd1);
        chk("t3_int_pending", 32'(int_pending_o), 32'd1);
        chk("t3_step_cnt", 32'(step_cnt_o), 32'd0);
        pulse_clr();
        dly[2] = 3; dly[0] = 3; dly[1] = 3;

        // 4: abort during Ez of step 2, then a fresh run
        do_start(5);
        wait_for("t4_reach_ez", 1'b1, 1, 100);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("t4_busy", 32'(busy_o), 32'd0);
        chk("t4_ez_en", 32'(eng_if.calc_Ez_start_en_o), 32'd0);
        chk("t4_int_pending", 32'(int_pending_o), 32'd0);
        chk("t4_step_cnt", 32'(step_cnt_o), 32'd1);
        do_start(1);
        wait_idle("t4_rerun", 100);
        chk("t4_rerun_step", 32'(step_cnt_o), 32'd1);
        chk("t4_rerun_timeout", 32'(timeout_o), 32'd0);
        pulse_clr();

        // 5: clear coincident with final step end, later clear, zero-length start
        do_start(2);
        wait_for("t5_final_end", 1'b0, 1, 100);
        clr_int_i = 1'b1;
        @(negedge clk);
        clr_int_i = 1'b0;
        chk("t5_set_wins", 32'(int_pending_o), 32'd1);
        pulse_clr();
        chk("t5_cleared", 32'(int_pending_o), 32'd0);
        do_start(0);
        @(negedge clk);
        chk("t5_n0_busy", 32'(busy_o), 32'd0);
        chk("t5_n0_int", 32'(int_pending_o), 32'd0);

        // Random traffic, with one asynchronous reset mid-stream
        for (int c = 0; c < 3000; c++) begin
            start_i = ($urandom_range(0, 15) == 0);
            num_steps_i = STEP_W'($urandom_range(0, 4));
            abort_i = ($urandom_range(0, 120) == 0);
            clr_int_i = ($urandom_range(0, 25) == 0);
            if ($urandom_range(0, 40) == 0) int_en_i = ~int_en_i;
            if (!busy_o) begin
                for (int i = 0; i < 3; i++)
                    dly[i] = ($urandom_range(0, 12) == 0) ? 0 : int'($urandom_range(1, 6));
            end
            if (c == 1500) begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        start_i = 1'b0; abort_i = 1'b0; clr_int_i = 1'b0;
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
